// File: rtl/fano_pkg.sv
// Shared types and constants for the Fano sync-search controller and the
// register block that reports its status.
package fano_pkg;

  // o_state encoding, also read back through the read-only status register
  localparam logic [1:0] STATE_CODE_IDLE   = 2'd0;
  localparam logic [1:0] STATE_CODE_APPLY  = 2'd1;
  localparam logic [1:0] STATE_CODE_DWELL  = 2'd2;
  localparam logic [1:0] STATE_CODE_LOCKED = 2'd3;

  localparam int RST_LEN_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = STATE_CODE_IDLE,
    ST_APPLY  = STATE_CODE_APPLY,
    ST_DWELL  = STATE_CODE_DWELL,
    ST_LOCKED = STATE_CODE_LOCKED
  } fano_state_t;

endpackage

// File: rtl/fano_sync_search_ctrl_if.sv
// Configuration, decoder-status and hypothesis signals between the register
// block / decoder core (master) and the sync-search controller (slave).
interface fano_sync_search_ctrl_if #(
  parameter int ANGLE_W = 3,
  parameter int LLR_W   = 3,
  parameter int DWELL_W = 24,
  parameter int LOST_W  = 16
);
  // No valid/ready handshake on this boundary: config and i_sync are levels
  // sampled every cycle, i_restart is a one-cycle pulse, outputs are registered.
  logic               i_enable;
  logic               i_restart;
  logic [ANGLE_W-1:0] i_angle_max;
  logic [LLR_W-1:0]   i_llr_max;
  logic [DWELL_W-1:0] i_dwell;
  logic [LOST_W-1:0]  i_lost_thr;
  logic               i_sync;
  logic [ANGLE_W-1:0] o_angle_step;
  logic [LLR_W-1:0]   o_llr_order;
  logic               o_dec_reset;
  logic               o_locked;
  logic [1:0]         o_state;
  logic [7:0]         o_sweep_cnt;

  modport master (
    output i_enable, i_restart, i_angle_max, i_llr_max, i_dwell, i_lost_thr, i_sync,
    input  o_angle_step, o_llr_order, o_dec_reset, o_locked, o_state, o_sweep_cnt
  );

  modport slave (
    input  i_enable, i_restart, i_angle_max, i_llr_max, i_dwell, i_lost_thr, i_sync,
    output o_angle_step, o_llr_order, o_dec_reset, o_locked, o_state, o_sweep_cnt
  );

endinterface

// File: rtl/fano_hyp_step.sv
// Next hypothesis in the {llr_order, angle_step} sweep; angle is the fast index.
// A field already above its max counts as at-max and wraps to 0.
module fano_hyp_step #(
  parameter int ANGLE_W = 3,
  parameter int LLR_W   = 3
) (
  input  logic [ANGLE_W-1:0] cur_angle,
  input  logic [LLR_W-1:0]   cur_llr,
  input  logic [ANGLE_W-1:0] angle_max,
  input  logic [LLR_W-1:0]   llr_max,
  output logic [ANGLE_W-1:0] next_angle,
  output logic [LLR_W-1:0]   next_llr,
  output logic               wrap
);

  always_comb begin
    next_angle = cur_angle;
    next_llr   = cur_llr;
    wrap       = 1'b0;
    if (cur_angle < angle_max) begin
      next_angle = cur_angle + ANGLE_W'(1);
    end else begin
      next_angle = '0;
      if (cur_llr < llr_max) begin
        next_llr = cur_llr + LLR_W'(1);
      end else begin
        next_llr = '0;
        wrap     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fano_sync_search_ctrl.sv
// Acquisition scheduler for one Fano decoder channel: sweeps hypotheses with a
// decoder reset pulse and dwell per step, locks on sync, re-searches on loss.
module fano_sync_search_ctrl
  import fano_pkg::*;
#(
  parameter int ANGLE_W = 3,
  parameter int LLR_W   = 3,
  parameter int DWELL_W = 24,
  parameter int LOST_W  = 16,
  parameter int RST_LEN = RST_LEN_DEFAULT
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  fano_sync_search_ctrl_if.slave bus
);

  localparam int RST_CW = (RST_LEN > 1) ? $clog2(RST_LEN) : 1;
  localparam logic [RST_CW-1:0] RST_CNT_LAST = RST_CW'(RST_LEN - 1);

  fano_state_t        state_q, state_n;
  logic [ANGLE_W-1:0] angle_q, angle_n, step_angle;
  logic [LLR_W-1:0]   llr_q, llr_n, step_llr;
  logic               step_wrap;
  logic [7:0]         sweep_q, sweep_n;
  logic [RST_CW-1:0]  rst_cnt_q, rst_cnt_n;
  logic [DWELL_W-1:0] dwell_q, dwell_n, dwell_last;
  logic [LOST_W-1:0]  lost_q, lost_n;
  logic [LOST_W:0]    lost_inc, lost_lim;
  logic               dec_reset_q, locked_q;

  fano_hyp_step #(
    .ANGLE_W (ANGLE_W),
    .LLR_W   (LLR_W)
  ) u_hyp_step (
    .cur_angle  (angle_q),
    .cur_llr    (llr_q),
    .angle_max  (bus.i_angle_max),
    .llr_max    (bus.i_llr_max),
    .next_angle (step_angle),
    .next_llr   (step_llr),
    .wrap       (step_wrap)
  );

  // Zero limits behave as one; config is live, so compare with >= not ==.
  assign dwell_last = (bus.i_dwell == '0) ? '0 : bus.i_dwell - DWELL_W'(1);
  assign lost_inc   = {1'b0, lost_q} + (LOST_W + 1)'(1);
  assign lost_lim   = (bus.i_lost_thr == '0) ? (LOST_W + 1)'(1) : {1'b0, bus.i_lost_thr};

  always_comb begin
    state_n   = state_q;
    angle_n   = angle_q;
    llr_n     = llr_q;
    sweep_n   = sweep_q;
    rst_cnt_n = '0;
    dwell_n   = '0;
    lost_n    = '0;
    if (!bus.i_enable) begin
      state_n = ST_IDLE;
    end else if (bus.i_restart) begin
      state_n = ST_APPLY;
      angle_n = '0;
      llr_n   = '0;
      sweep_n = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_n = ST_APPLY;
        ST_APPLY: begin
          if (rst_cnt_q >= RST_CNT_LAST) state_n = ST_DWELL;
          else rst_cnt_n = rst_cnt_q + RST_CW'(1);
        end
        ST_DWELL: begin
          if (bus.i_sync) begin
            state_n = ST_LOCKED;
          end else if (dwell_q >= dwell_last) begin
            state_n = ST_APPLY;
            angle_n = step_angle;
            llr_n   = step_llr;
            if (step_wrap && sweep_q != 8'hFF) sweep_n = sweep_q + 8'd1;
          end else begin
            dwell_n = dwell_q + DWELL_W'(1);
          end
        end
        default: begin
          if (bus.i_sync) lost_n = '0;
          else if (lost_inc >= lost_lim) state_n = ST_APPLY;
          else lost_n = lost_inc[LOST_W-1:0];
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      angle_q     <= '0;
      llr_q       <= '0;
      sweep_q     <= '0;
      rst_cnt_q   <= '0;
      dwell_q     <= '0;
      lost_q      <= '0;
      dec_reset_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_n;
      angle_q     <= angle_n;
      llr_q       <= llr_n;
      sweep_q     <= sweep_n;
      rst_cnt_q   <= rst_cnt_n;
      dwell_q     <= dwell_n;
      lost_q      <= lost_n;
      dec_reset_q <= (state_n == ST_APPLY);
      locked_q    <= (state_n == ST_LOCKED);
    end
  end

  assign bus.o_angle_step = angle_q;
  assign bus.o_llr_order  = llr_q;
  assign bus.o_dec_reset  = dec_reset_q;
  assign bus.o_locked     = locked_q;
  assign bus.o_state      = state_q;
  assign bus.o_sweep_cnt  = sweep_q;

endmodule

// File: tb/tb_fano_sync_search_ctrl.sv
// Bench for fano_sync_search_ctrl: directed vector table, hand sequences for
// edge cases, then random stimulus, all checked every cycle against a model.
module tb_fano_sync_search_ctrl;
  localparam int ANGLE_W = 3;
  localparam int LLR_W   = 3;
  localparam int DWELL_W = 24;
  localparam int LOST_W  = 16;
  localparam int RST_LEN = 16;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  always #5 i_clk = ~i_clk;

  fano_sync_search_ctrl_if #(
    .ANGLE_W(ANGLE_W), .LLR_W(LLR_W), .DWELL_W(DWELL_W), .LOST_W(LOST_W)
  ) bus ();

  fano_sync_search_ctrl #(
    .ANGLE_W(ANGLE_W), .LLR_W(LLR_W), .DWELL_W(DWELL_W), .LOST_W(LOST_W),
    .RST_LEN(RST_LEN)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_mis = 0;

  // ---------------- reference model ----------------
  // m_st: 0 idle, 1 reset pulse, 2 dwell, 3 locked
  int m_st, m_a, m_l, m_sw, m_pulse, m_dw, m_low;

  task automatic model_reset();
    m_st = 0; m_a = 0; m_l = 0; m_sw = 0; m_pulse = 0; m_dw = 0; m_low = 0;
  endtask

  task automatic enter_apply();
    m_st = 1;
    m_pulse = 0;
  endtask

  task automatic model_advance();
    int amax, lmax;
    amax = int'(bus.i_angle_max);
    lmax = int'(bus.i_llr_max);
    if (m_a < amax) m_a++;
    else begin
      m_a = 0;
      if (m_l < lmax) m_l++;
      else begin
        m_l = 0;
        if (m_sw < 255) m_sw++;
      end
    end
  endtask

  task automatic model_step();
    int eff_dw, eff_thr;
    if (i_reset) begin
      model_reset();
      return;
    end
    eff_dw  = (bus.i_dwell == 0) ? 1 : int'(bus.i_dwell);
    eff_thr = (bus.i_lost_thr == 0) ? 1 : int'(bus.i_lost_thr);
    if (!bus.i_enable) m_st = 0;
    else if (bus.i_restart) begin
      m_a = 0; m_l = 0; m_sw = 0;
      enter_apply();
    end else begin
      case (m_st)
        0: enter_apply();
        1: begin
          m_pulse++;
          if (m_pulse >= RST_LEN) begin m_st = 2; m_dw = 0; end
        end
        2: begin
          m_dw++;
          if (bus.i_sync) begin m_st = 3; m_low = 0; end
          else if (m_dw >= eff_dw) begin model_advance(); enter_apply(); end
        end
        default: begin
          if (bus.i_sync) m_low = 0;
          else m_low++;
          if (m_low >= eff_thr) enter_apply();
        end
      endcase
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic cmp(string tag, logic [1:0] st, logic dr, logic lk, int a, int l, int s);
    n_vec++;
    if (bus.o_state !== st) begin
      $display("FAIL %s o_state got %0d want %0d", tag, bus.o_state, st); n_mis++;
    end
    if (bus.o_dec_reset !== dr) begin
      $display("FAIL %s o_dec_reset got %0d want %0d", tag, bus.o_dec_reset, dr); n_mis++;
    end
    if (bus.o_locked !== lk) begin
      $display("FAIL %s o_locked got %0d want %0d", tag, bus.o_locked, lk); n_mis++;
    end
    if (int'(bus.o_angle_step) != a) begin
      $display("FAIL %s o_angle_step got %0d want %0d", tag, bus.o_angle_step, a); n_mis++;
    end
    if (int'(bus.o_llr_order) != l) begin
      $display("FAIL %s o_llr_order got %0d want %0d", tag, bus.o_llr_order, l); n_mis++;
    end
    if (int'(bus.o_sweep_cnt) != s) begin
      $display("FAIL %s o_sweep_cnt got %0d want %0d", tag, bus.o_sweep_cnt, s); n_mis++;
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, check #1 later.
  task automatic cycle(string tag);
    @(posedge i_clk);
    model_step();
    #1;
    cmp(tag, 2'(m_st), (m_st == 1), (m_st == 3), m_a, m_l, m_sw);
  endtask

  task automatic run(string tag, int n);
    for (int k = 0; k < n; k++) cycle(tag);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    cycle("rst");
    cycle("rst");
    i_reset = 1'b0;
  endtask

  task automatic set_cfg(int dwell, int amax, int lmax, int thr);
    bus.i_dwell     = DWELL_W'(dwell);
    bus.i_angle_max = ANGLE_W'(amax);
    bus.i_llr_max   = LLR_W'(lmax);
    bus.i_lost_thr  = LOST_W'(thr);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int         n;
    logic       en, rs, sync;
    logic [1:0] st;
    logic       dr, lk;
    int         a, l, s;
  } vec_t;

  localparam int NV = 28;
  vec_t tbl[NV];

  function automatic vec_t mk(int n, logic en, logic rs, logic sync, logic [1:0] st,
                              logic dr, logic lk, int a, int l, int s);
    vec_t v;
    v.n = n; v.en = en; v.rs = rs; v.sync = sync; v.st = st;
    v.dr = dr; v.lk = lk; v.a = a; v.l = l; v.s = s;
    return v;
  endfunction

  initial begin
    // dwell=10, angle_max=2, llr_max=1, lost_thr=5; each hypothesis = 16+10 cycles
    tbl[0]  = mk(1,   1, 0, 0, 2'd1, 1, 0, 0, 0, 0);
    tbl[1]  = mk(15,  1, 0, 0, 2'd1, 1, 0, 0, 0, 0);
    tbl[2]  = mk(1,   1, 0, 0, 2'd2, 0, 0, 0, 0, 0);
    tbl[3]  = mk(9,   1, 0, 0, 2'd2, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1,   1, 0, 0, 2'd1, 1, 0, 1, 0, 0);
    tbl[5]  = mk(26,  1, 0, 0, 2'd1, 1, 0, 2, 0, 0);
    tbl[6]  = mk(26,  1, 0, 0, 2'd1, 1, 0, 0, 1, 0);
    tbl[7]  = mk(26,  1, 0, 0, 2'd1, 1, 0, 1, 1, 0);
    tbl[8]  = mk(26,  1, 0, 0, 2'd1, 1, 0, 2, 1, 0);
    tbl[9]  = mk(25,  1, 0, 0, 2'd2, 0, 0, 2, 1, 0);
    tbl[10] = mk(1,   1, 0, 0, 2'd1, 1, 0, 0, 0, 1);
    tbl[11] = mk(155, 1, 0, 0, 2'd2, 0, 0, 2, 1, 1);
    tbl[12] = mk(1,   1, 0, 1, 2'd3, 0, 1, 2, 1, 1);
    tbl[13] = mk(4,   1, 0, 0, 2'd3, 0, 1, 2, 1, 1);
    tbl[14] = mk(1,   1, 0, 1, 2'd3, 0, 1, 2, 1, 1);
    tbl[15] = mk(4,   1, 0, 0, 2'd3, 0, 1, 2, 1, 1);
    tbl[16] = mk(1,   1, 0, 0, 2'd1, 1, 0, 2, 1, 1);
    tbl[17] = mk(26,  1, 0, 0, 2'd1, 1, 0, 0, 0, 2);
    tbl[18] = mk(156, 1, 0, 0, 2'd1, 1, 0, 0, 0, 3);
    tbl[19] = mk(26,  1, 0, 0, 2'd1, 1, 0, 1, 0, 3);
    tbl[20] = mk(16,  1, 0, 0, 2'd2, 0, 0, 1, 0, 3);
    tbl[21] = mk(1,   1, 0, 1, 2'd3, 0, 1, 1, 0, 3);
    tbl[22] = mk(1,   1, 1, 1, 2'd1, 1, 0, 0, 0, 0);
    tbl[23] = mk(15,  1, 0, 0, 2'd1, 1, 0, 0, 0, 0);
    tbl[24] = mk(1,   1, 0, 0, 2'd2, 0, 0, 0, 0, 0);
    tbl[25] = mk(10,  1, 0, 0, 2'd1, 1, 0, 1, 0, 0);
    tbl[26] = mk(1,   0, 1, 0, 2'd0, 0, 0, 1, 0, 0);
    tbl[27] = mk(1,   1, 0, 0, 2'd1, 1, 0, 1, 0, 0);

    bus.i_enable  = 1'b1;
    bus.i_restart = 1'b0;
    bus.i_sync    = 1'b0;
    set_cfg(10, 2, 1, 5);
    model_reset();

    do_reset();
    cmp("reset_state", 2'd0, 1'b0, 1'b0, 0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      bus.i_enable  = tbl[i].en;
      bus.i_restart = tbl[i].rs;
      bus.i_sync    = tbl[i].sync;
      run("tbl_run", tbl[i].n);
      cmp($sformatf("tbl%0d", i), tbl[i].st, tbl[i].dr, tbl[i].lk, tbl[i].a, tbl[i].l, tbl[i].s);
    end
    bus.i_restart = 1'b0;

    // reset asserted mid-APPLY clears outputs before the next clock edge
    i_reset = 1'b1;
    #2;
    cmp("async_rst", 2'd0, 1'b0, 1'b0, 0, 0, 0);
    do_reset();

    // dwell=0 acts as 1, maxes 0: every hypothesis is one full sweep of 17 cycles
    set_cfg(0, 0, 0, 0);
    do_reset();
    run("dwell0", 18);
    cmp("dwell0_first", 2'd1, 1'b1, 1'b0, 0, 0, 1);
    run("sat", 299 * 17);
    cmp("sat_255", 2'd1, 1'b1, 1'b0, 0, 0, 255);
    run("sat", 17);
    cmp("sat_hold", 2'd1, 1'b1, 1'b0, 0, 0, 255);

    // sync is ignored during the reset pulse, then lost_thr=0 acts as 1
    bus.i_sync = 1'b1;
    run("apply_sync", 15);
    cmp("apply_ign_sync", 2'd1, 1'b1, 1'b0, 0, 0, 255);
    run("apply_sync", 1);
    cmp("dwell_after_apply", 2'd2, 1'b0, 1'b0, 0, 0, 255);
    run("lock", 1);
    cmp("lock_thr0", 2'd3, 1'b0, 1'b1, 0, 0, 255);
    bus.i_sync = 1'b0;
    run("thr0", 1);
    cmp("thr0_loss", 2'd1, 1'b1, 1'b0, 0, 0, 255);

    // lowering angle_max below the current angle wraps on the next advance
    set_cfg(1, 7, 7, 3);
    do_reset();
    run("amax", 1 + 17 * 5);
    cmp("angle5", 2'd1, 1'b1, 1'b0, 5, 0, 0);
    bus.i_angle_max = ANGLE_W'(2);
    run("amax", 17);
    cmp("amax_lower", 2'd1, 1'b1, 1'b0, 0, 1, 0);

    // random stimulus checked against the model every cycle
    set_cfg(3, 2, 1, 2);
    for (int c = 0; c < 4000; c++) begin
      if (c % 60 == 0)
        set_cfg($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 4));
      bus.i_enable  = ($urandom_range(0, 99) < 97);
      bus.i_restart = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) < 2) bus.i_sync = ~bus.i_sync;
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    if (n_mis == 0) $display("TEST PASSED");
    else $display("TEST FAILED");
    $finish;
  end

endmodule
